// File: rtl/fault_cam_collector.sv
// Fault CAM collector: classifies incoming BIST fault addresses into pivot
// and non-pivot CAM entries, drops duplicates, tracks per-pivot fault counts
// and must-repair flags, and raises cam_done once BIST has finished.
`timescale 1ns/1ps
module fault_cam_collector #(
  parameter int PCAM      = 8,
  parameter int NPCAM     = 30,
  parameter int ROW_SPARE = 2,
  parameter int COL_SPARE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  fault_valid,
  output logic                  fault_ready,
  input  logic [9:0]            fault_row,
  input  logic [9:0]            fault_col,
  input  logic                  bist_done,
  output logic [PCAM*26-1:0]    pivot_fault_addr,
  output logic [NPCAM*17-1:0]   nonpivot_fault_addr,
  output logic [3:0]            pcam_count,
  output logic [4:0]            npcam_count,
  output logic                  unrepairable,
  output logic                  cam_done
);

  localparam int         PW        = $clog2(PCAM);
  localparam int         NW        = $clog2(NPCAM);
  localparam logic [2:0] ROW_LIM   = 3'(ROW_SPARE);
  localparam logic [2:0] COL_LIM   = 3'(COL_SPARE);
  localparam logic [3:0] PCAM_MAX  = 4'(PCAM);
  localparam logic [4:0] NPCAM_MAX = 5'(NPCAM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // 3-bit fault counter increment that saturates at 7.
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    sat_inc = (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  logic              accept_s;
  logic              flush_s;
  logic              fault_ready_r;
  logic              cam_done_r;

  logic [9:0]        f_row_r;
  logic [9:0]        f_col_r;

  logic [PCAM-1:0]   p_valid_r;
  logic [9:0]        p_row_r  [PCAM];
  logic [9:0]        p_col_r  [PCAM];
  logic [2:0]        p_rcnt_r [PCAM];
  logic [2:0]        p_ccnt_r [PCAM];
  logic [PCAM-1:0]   p_rmust_r;
  logic [PCAM-1:0]   p_cmust_r;

  logic [NPCAM-1:0]  np_valid_r;
  logic [2:0]        np_ptr_r  [NPCAM];
  logic [NPCAM-1:0]  np_dir_r;
  logic [9:0]        np_addr_r [NPCAM];

  logic [3:0]        pcam_count_r;
  logic [4:0]        npcam_count_r;
  logic              unrep_r;

  logic [PCAM-1:0]   prow_s;
  logic [PCAM-1:0]   pcol_s;
  logic              dup_s;
  logic [PCAM-1:0]   prow_r;
  logic [PCAM-1:0]   pcol_r;
  logic              dup_r;

  logic              any_row_s;
  logic              any_col_s;
  logic [2:0]        sel_ptr_s;
  logic              sel_dir_s;
  logic              wr_np_s;
  logic              wr_p_s;
  logic [2:0]        inc_row_s;
  logic [2:0]        inc_col_s;
  logic [PW-1:0]     pidx_s;
  logic [NW-1:0]     nidx_s;

  assign pidx_s = pcam_count_r[PW-1:0];
  assign nidx_s = npcam_count_r[NW-1:0];

  // FSM state plus the registered handshake/status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      fault_ready_r <= 1'b1;
      cam_done_r    <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      fault_ready_r <= (state_next_s == ST_IDLE);
      cam_done_r    <= (state_next_s == ST_DONE);
    end
  end

  // Next-state decode; a pending fault wins over bist_done in IDLE.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    flush_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear) begin
          flush_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
        if (fault_valid) begin
          accept_s     = 1'b1;
          state_next_s = ST_CMP;
        end else if (bist_done) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CMP:  state_next_s = ST_WR;
      ST_WR:   state_next_s = ST_IDLE;
      ST_DONE: begin
        if (clear) begin
          flush_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Capture the accepted fault address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_row_r <= 10'd0;
      f_col_r <= 10'd0;
    end else if (accept_s) begin
      f_row_r <= fault_row;
      f_col_r <= fault_col;
    end
  end

  // Match the captured fault against every pivot and reconstructed non-pivot address.
  always_comb begin
    prow_s = '0;
    pcol_s = '0;
    dup_s  = 1'b0;
    for (int i = 0; i < PCAM; i++) begin
      prow_s[i] = p_valid_r[i] && (p_row_r[i] == f_row_r);
      pcol_s[i] = p_valid_r[i] && (p_col_r[i] == f_col_r);
      dup_s     = dup_s | (prow_s[i] & pcol_s[i]);
    end
    for (int j = 0; j < NPCAM; j++) begin
      dup_s = dup_s | (np_valid_r[j] &&
              (np_dir_r[j] ? ((p_col_r[np_ptr_r[j]] == f_col_r) && (np_addr_r[j] == f_row_r))
                           : ((p_row_r[np_ptr_r[j]] == f_row_r) && (np_addr_r[j] == f_col_r))));
    end
  end

  // Register the match vectors during the compare cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prow_r <= '0;
      pcol_r <= '0;
      dup_r  <= 1'b0;
    end else if (state_r == ST_CMP) begin
      prow_r <= prow_s;
      pcol_r <= pcol_s;
      dup_r  <= dup_s;
    end
  end

  // Write decode: lowest row-matching pivot, else lowest column-matching pivot.
  always_comb begin
    any_row_s = |prow_r;
    any_col_s = |pcol_r;
    sel_ptr_s = 3'd0;
    for (int i = PCAM - 1; i >= 0; i--) begin
      if (any_row_s ? prow_r[i] : pcol_r[i]) begin
        sel_ptr_s = 3'(i);
      end else begin
        sel_ptr_s = sel_ptr_s;
      end
    end
    sel_dir_s = ~any_row_s;
    wr_np_s   = (state_r == ST_WR) && !dup_r && (any_row_s || any_col_s);
    wr_p_s    = (state_r == ST_WR) && !dup_r && !(any_row_s || any_col_s);
    inc_row_s = sat_inc(p_rcnt_r[sel_ptr_s]);
    inc_col_s = sat_inc(p_ccnt_r[sel_ptr_s]);
  end

  // CAM storage, counts, must-repair flags and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_r     <= '0;
      p_rmust_r     <= '0;
      p_cmust_r     <= '0;
      np_valid_r    <= '0;
      np_dir_r      <= '0;
      pcam_count_r  <= 4'd0;
      npcam_count_r <= 5'd0;
      unrep_r       <= 1'b0;
      for (int i = 0; i < PCAM; i++) begin
        p_row_r[i]  <= 10'd0;
        p_col_r[i]  <= 10'd0;
        p_rcnt_r[i] <= 3'd0;
        p_ccnt_r[i] <= 3'd0;
      end
      for (int j = 0; j < NPCAM; j++) begin
        np_ptr_r[j]  <= 3'd0;
        np_addr_r[j] <= 10'd0;
      end
    end else if (flush_s) begin
      p_valid_r     <= '0;
      p_rmust_r     <= '0;
      p_cmust_r     <= '0;
      np_valid_r    <= '0;
      np_dir_r      <= '0;
      pcam_count_r  <= 4'd0;
      npcam_count_r <= 5'd0;
      unrep_r       <= 1'b0;
      for (int i = 0; i < PCAM; i++) begin
        p_row_r[i]  <= 10'd0;
        p_col_r[i]  <= 10'd0;
        p_rcnt_r[i] <= 3'd0;
        p_ccnt_r[i] <= 3'd0;
      end
      for (int j = 0; j < NPCAM; j++) begin
        np_ptr_r[j]  <= 3'd0;
        np_addr_r[j] <= 10'd0;
      end
    end else if (wr_np_s) begin
      if (npcam_count_r == NPCAM_MAX) begin
        unrep_r <= 1'b1;
      end else begin
        np_valid_r[nidx_s] <= 1'b1;
        np_ptr_r[nidx_s]   <= sel_ptr_s;
        np_dir_r[nidx_s]   <= sel_dir_s;
        np_addr_r[nidx_s]  <= sel_dir_s ? f_row_r : f_col_r;
        npcam_count_r      <= npcam_count_r + 5'd1;
        if (!sel_dir_s) begin
          p_rcnt_r[sel_ptr_s] <= inc_row_s;
          if (inc_row_s > COL_LIM) begin
            p_rmust_r[sel_ptr_s] <= 1'b1;
          end
        end else begin
          p_ccnt_r[sel_ptr_s] <= inc_col_s;
          if (inc_col_s > ROW_LIM) begin
            p_cmust_r[sel_ptr_s] <= 1'b1;
          end
        end
      end
    end else if (wr_p_s) begin
      if (pcam_count_r == PCAM_MAX) begin
        unrep_r <= 1'b1;
      end else begin
        p_valid_r[pidx_s] <= 1'b1;
        p_row_r[pidx_s]   <= f_row_r;
        p_col_r[pidx_s]   <= f_col_r;
        p_rcnt_r[pidx_s]  <= 3'd1;
        p_ccnt_r[pidx_s]  <= 3'd1;
        p_rmust_r[pidx_s] <= (3'd1 > COL_LIM);
        p_cmust_r[pidx_s] <= (3'd1 > ROW_LIM);
        pcam_count_r      <= pcam_count_r + 4'd1;
      end
    end
  end

  // Pack the CAM registers into the flat images read by the analyzer.
  always_comb begin
    pivot_fault_addr    = '0;
    nonpivot_fault_addr = '0;
    for (int i = 0; i < PCAM; i++) begin
      pivot_fault_addr[i*26 +: 26] = {p_valid_r[i], p_row_r[i], p_col_r[i],
                                      p_rmust_r[i], p_cmust_r[i], 3'b000};
    end
    for (int j = 0; j < NPCAM; j++) begin
      nonpivot_fault_addr[j*17 +: 17] = {np_valid_r[j], np_ptr_r[j], np_dir_r[j],
                                         2'b00, np_addr_r[j]};
    end
  end

  assign fault_ready  = fault_ready_r;
  assign cam_done     = cam_done_r;
  assign pcam_count   = pcam_count_r;
  assign npcam_count  = npcam_count_r;
  assign unrepairable = unrep_r;

endmodule
